seq_int_divider: RTL and testbench

Iterative restoring integer divider that produces Verilog-semantics quotient/remainder for signed or unsigned operands (truncate toward zero, remainder takes dividend sign). It sits downstream of the expression/arithmetic evaluation stage and consumes its divide operations, one bit per cycle. Results go to the writeback stage through a valid/ready output.

---
 rtl/seq_int_divider_pkg.sv | 11 +
 rtl/seq_int_divider_div_step.sv | 23 ++
 rtl/seq_int_divider.sv | 145 ++++++++++++++
 tb/tb_seq_int_divider.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_int_divider_pkg.sv
// Shared types for the sequential integer divider: FSM state encoding.
package seq_int_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/seq_int_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module seq_int_divider_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quo_bit_o
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // rem_i < divisor_i, so partial < 2*divisor_i and diff[WIDTH] is a valid borrow flag.
  always_comb begin
    partial   = {rem_i, quo_msb_i};
    diff      = partial - {1'b0, divisor_i};
    quo_bit_o = ~diff[WIDTH];
    rem_o     = quo_bit_o ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_int_divider.sv
// Iterative restoring divider, Verilog-semantics signed/unsigned quotient and remainder.
// Optional SEQ_INT_DIVIDER_FAST_ZERO_EN: zero dividend/divisor bypasses the iteration.
module seq_int_divider
  import seq_int_divider_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   orig_q, orig_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   step_rem;
  logic               step_bit;

  seq_int_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i    (rem_q),
    .quo_msb_i(quo_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_bit_o(step_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    orig_d      = orig_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StDone);
    a_neg       = signed_mode & dividend[WIDTH-1];
    b_neg       = signed_mode & divisor[WIDTH-1];

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Magnitudes are WIDTH-bit unsigned, so |-2^(WIDTH-1)| is represented exactly.
          quo_d    = a_neg ? -dividend : dividend;
          dvs_d    = b_neg ? -divisor : divisor;
          rem_d    = '0;
          orig_d   = dividend;
          sign_q_d = a_neg ^ b_neg;
          sign_r_d = a_neg;
          zero_d   = (divisor == '0);
          cnt_d    = CNT_W'(WIDTH);
          state_d  = StIter;
`ifdef SEQ_INT_DIVIDER_FAST_ZERO_EN
          if (divisor == '0 || dividend == '0) state_d = StFix;
`endif
        end
      end
      StIter: begin
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = orig_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = sign_q_q ? -quo_q : quo_q;
          remainder_d = sign_r_q ? -rem_q : rem_q;
          dbz_d       = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      orig_q      <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      orig_q      <= orig_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_int_divider.sv
// Scoreboard bench for seq_int_divider: directed cases, backpressure, reset abort, random ops.
module tb_seq_int_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];

  seq_int_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .signed_mode(signed_mode),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, which truncates toward zero like the spec requires.
  function automatic exp_t model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ai, bi;
    e.acc = 0;
`ifdef SEQ_INT_DIVIDER_FAST_ZERO_EN
    e.lat = (a == 0 || b == 0) ? 2 : W + 2;
`else
    e.lat = W + 2;
`endif
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      if (sm) begin
        ai = int'($signed(a));
        bi = int'($signed(b));
      end else begin
        ai = int'({16'h0, a});
        bi = int'({16'h0, b});
      end
      e.q   = W'(ai / bi);
      e.r   = W'(ai % bi);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0:       return '0;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Called just after a rising edge.
  task automatic do_op(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
    int   t = 0;
    exp_t e;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0, expected 1 (cycle %0d)", cyc);
      return;
    end
    e     = model(sm, a, b);
    e.acc = cyc;
    sb.push_back(e);
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 2) ? (($urandom % 4) != 0) : rdy_mode[0];
    end
  end

  initial begin : monitor
    bit           seen;
    bit           holding;
    logic [W-1:0] hq, hr;
    logic         hd;
    exp_t         e;
    seen    = 0;
    holding = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen    = 0;
        holding = 0;
      end else if (out_valid) begin
        check("in_ready_while_done", {31'b0, in_ready}, 32'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got q=%0h, expected none", quotient);
        end else begin
          if (!seen) begin
            check("latency", cyc - sb[0].acc, sb[0].lat);
            seen = 1;
          end
          if (holding) begin
            check("hold_quotient", {16'b0, quotient}, {16'b0, hq});
            check("hold_remainder", {16'b0, remainder}, {16'b0, hr});
            check("hold_dbz", {31'b0, div_by_zero}, {31'b0, hd});
          end
          if (out_ready) begin
            e = sb.pop_front();
            check("quotient", {16'b0, quotient}, {16'b0, e.q});
            check("remainder", {16'b0, remainder}, {16'b0, e.r});
            check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
            seen    = 0;
            holding = 0;
          end else begin
            holding = 1;
            hq      = quotient;
            hr      = remainder;
            hd      = div_by_zero;
          end
        end
      end
    end
  end

  initial begin : stim
    int t;
    rst         = 1'b1;
    in_valid    = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_quotient", {16'b0, quotient}, 32'd0);
    check("rst_remainder", {16'b0, remainder}, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;

    do_op(1'b1, 16'hFFF4, 16'd3);
    do_op(1'b0, 16'hFFF4, 16'd3);
    do_op(1'b1, 16'hFFF9, 16'd2);
    do_op(1'b1, 16'h0007, 16'hFFFE);
    do_op(1'b0, 16'h1234, 16'h0000);
    do_op(1'b1, 16'hFFF0, 16'h0000);
    do_op(1'b1, 16'h8000, 16'hFFFF);
    do_op(1'b1, 16'h0000, 16'h0005);
    do_op(1'b0, 16'hFFFF, 16'hFFFF);
    drain();

    // Backpressure: hold out_ready low for several cycles once the result is up.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    do_op(1'b1, 16'h0100, 16'h0007);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    rdy_mode = 1;
    drain();

    // Reset in the middle of an iteration aborts the operation.
    do_op(1'b0, 16'h1234, 16'h0005);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_quotient", {16'b0, quotient}, 32'd0);
    check("abort_remainder", {16'b0, remainder}, 32'd0);
    rst = 1'b0;
    do_op(1'b0, 16'd100, 16'd7);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      do_op(1'($urandom % 2), pick(), pick());
    end
    drain();
    rdy_mode = 1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
